// File: rtl/multicycle_main_controller.sv
// Multi-cycle main controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes, handshakes memory
// through mem_ready, and traps illegal opcodes and memory-wait timeouts in
// an absorbing FAULT state that only rst_n can leave.
module multicycle_main_controller #(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                illegal,
  output logic                timeout_err,
  output logic                retire,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_LUI,
    CLS_BAD
  } op_class_t;

  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_LUI    = OPCODE_W'(7'b0110111);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_CMP = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_RF  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_IF  = ALUOP_W'(2'b11);

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Last wait-counter value before a stalled access is declared dead.
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_LUI:    return CLS_LUI;
      default:   return CLS_BAD;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic                  illegal_d, timeout_d;
  op_class_t             cls_in, cls_q;
  logic                  wait_expired;

  // Legality is judged on the live opcode in DECODE; everything after
  // DECODE works from the captured copy.
  assign cls_in       = classify(opcode);
  assign cls_q        = classify(opcode_q);
  assign wait_expired = (wait_cnt == LAST_WAIT) && !mem_ready;
  assign state        = state_q;

  // Next-state, wait counter, opcode capture and sticky fault flags.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_cnt_d = '0;
    illegal_d  = illegal;
    timeout_d  = timeout_err;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = FAULT;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      DECODE: begin
        opcode_d = opcode;
        if (cls_in == CLS_BAD) begin
          illegal_d = 1'b1;
          state_d   = FAULT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls_q)
          CLS_BRANCH:         state_d = FETCH;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          default:            state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == CLS_LOAD) ? WB : FETCH;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = FAULT;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      WB:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the control registers are reset; they are the whole state
    // of the block, so an asynchronous clear aborts any instruction at once.
    if (!rst_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_cnt    <= wait_cnt_d;
      illegal     <= illegal_d;
      timeout_err <= timeout_d;
    end
  end

  // Datapath strobes decoded from the current state and captured opcode;
  // only the memory handshake completions look at mem_ready.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = WB_ALU;
    reg_write  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      EXEC: begin
        case (cls_q)
          CLS_R: alu_op = ALU_RF;
          CLS_I: begin
            alu_op    = ALU_IF;
            alu_src_b = 1'b1;
          end
          CLS_LOAD, CLS_STORE: alu_src_b = 1'b1;
          CLS_BRANCH: begin
            alu_op = ALU_CMP;
            branch = 1'b1;
            pc_src = 1'b1;
            retire = 1'b1;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          CLS_LUI: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (cls_q == CLS_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          retire    = mem_ready;
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (cls_q == CLS_LOAD)     mem_to_reg = WB_MEM;
        else if (cls_q == CLS_JAL) mem_to_reg = WB_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: directed and random instruction
// streams; expected per-instruction summaries come from an abstract model
// and are matched by a monitor against what the controller actually did.
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_src, ir_write, alu_src_a, alu_src_b;
  logic [1:0] alu_op;
  logic       mem_read, mem_write;
  logic [1:0] mem_to_reg;
  logic       reg_write, branch, illegal, timeout_err, retire;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_main_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch(branch), .illegal(illegal),
    .timeout_err(timeout_err), .retire(retire), .state(state)
  );

  localparam int TMO = 15;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;
  localparam bit [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                       OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                       OP_LUI = 7'b0110111;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Everything observable about one instruction, summarised.
  typedef struct {
    bit fault; bit ill; bit tmo; bit has_exec;
    int cycles; int n_rd; int n_wr; int n_rw; int n_br;
    int n_pcw; int n_pcs; int n_irw; int wb_sel; int alu_op; int src_a; int src_b;
  } exp_t;

  exp_t sb[$];
  exp_t cur_fault;

  function automatic int op_kind(input bit [6:0] op);
    case (op)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_BR:   return K_BR;
      OP_JAL:  return K_JAL;
      OP_LUI:  return K_LUI;
      default: return -1;
    endcase
  endfunction

  // f = fetch wait cycles before mem_ready, m = data-memory wait cycles.
  function automatic exp_t model(input bit [6:0] op, input int f, input int m);
    exp_t e = '{default: 0};
    int k = op_kind(op);
    if (f >= TMO) begin
      e.fault = 1; e.tmo = 1; e.cycles = TMO; e.n_rd = TMO;
      return e;
    end
    e.cycles = f + 2;  // fetch cycles plus decode
    e.n_rd = f + 1; e.n_irw = 1; e.n_pcw = 1;
    if (k < 0) begin
      e.fault = 1; e.ill = 1;
      return e;
    end
    e.has_exec = 1;
    e.cycles++;
    case (k)
      K_R:   e.alu_op = 2;
      K_I:   begin e.alu_op = 3; e.src_b = 1; end
      K_LD, K_ST: e.src_b = 1;
      K_BR:  begin e.alu_op = 1; e.n_br = 1; e.n_pcs = 1; end
      K_JAL: begin e.n_pcw = 2; e.n_pcs = 1; end
      K_LUI: begin e.src_a = 1; e.src_b = 1; end
      default: ;
    endcase
    if (k == K_BR) return e;
    if (k == K_LD || k == K_ST) begin
      int acc = (m >= TMO) ? TMO : m + 1;
      e.cycles += acc;
      if (k == K_LD) e.n_rd += acc; else e.n_wr = acc;
      if (m >= TMO) begin
        e.fault = 1; e.tmo = 1;
        return e;
      end
      if (k == K_ST) return e;
    end
    e.cycles++;
    e.n_rw = 1;
    e.wb_sel = (k == K_LD) ? 1 : (k == K_JAL) ? 2 : 0;
    return e;
  endfunction

  function automatic bit [6:0] rand7();
    return 7'($urandom);
  endfunction

  function automatic bit rand1();
    return 1'($urandom);
  endfunction

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 12) return $urandom_range(0, 2);
    if (r < 17) return $urandom_range(3, 13);
    if (r == 17) return 14;
    if (r == 18) return 15;
    return 16;
  endfunction

  // One clock cycle of input: applied 1 time unit after the rising edge.
  task automatic drive(input bit rdy, input bit [6:0] op);
    mem_ready = rdy;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_illegal", illegal, 0);
    check("reset_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    drive(rand1(), rand7());  // IDLE cycle
  endtask

  task automatic fault_tail();
    repeat (4) drive(rand1(), rand7());
    do_reset();
  endtask

  task automatic run_instr(input bit [6:0] op, input int f, input int m);
    int k = op_kind(op);
    sb.push_back(model(op, f, m));
    for (int i = 0; i < f && i < TMO; i++) drive(1'b0, rand7());
    if (f >= TMO) begin fault_tail(); return; end
    drive(1'b1, rand7());          // fetch completes
    drive(rand1(), op);            // decode
    if (k < 0) begin fault_tail(); return; end
    drive(rand1(), op);            // exec
    if (k == K_BR) return;
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < m && i < TMO; i++) drive(1'b0, op);
      if (m >= TMO) begin fault_tail(); return; end
      drive(1'b1, op);
      if (k == K_ST) return;
    end
    drive(rand1(), op);            // writeback
  endtask

  // Monitor: accumulates what the controller did and, on each retire or
  // fault entry, matches it against the oldest expected summary.
  int  cyc, n_rd, n_wr, n_rw, n_br, n_pcw, n_pcs, n_irw, wb_sel, ex_op, ex_a, ex_b;
  bit  in_fault;
  logic [13:0] strobes;
  assign strobes = {pc_write, pc_src, ir_write, alu_src_a, alu_src_b, alu_op,
                    mem_read, mem_write, mem_to_reg, reg_write, branch, retire};

  task automatic clear_acc();
    cyc = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_br = 0; n_pcw = 0; n_pcs = 0;
    n_irw = 0; wb_sel = -1; ex_op = -1; ex_a = -1; ex_b = -1;
  endtask

  task automatic compare_txn(input bit is_fault);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_txn", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (is_fault) cur_fault = e;
    check("txn_kind_fault", is_fault, e.fault);
    check("txn_cycles", cyc, e.cycles);
    check("txn_mem_read_cycles", n_rd, e.n_rd);
    check("txn_mem_write_cycles", n_wr, e.n_wr);
    check("txn_reg_write_cycles", n_rw, e.n_rw);
    check("txn_branch_cycles", n_br, e.n_br);
    check("txn_pc_write_cycles", n_pcw, e.n_pcw);
    check("txn_pc_src_cycles", n_pcs, e.n_pcs);
    check("txn_ir_write_cycles", n_irw, e.n_irw);
    if (e.has_exec) begin
      check("exec_alu_op", ex_op, e.alu_op);
      check("exec_alu_src_a", ex_a, e.src_a);
      check("exec_alu_src_b", ex_b, e.src_b);
    end
    if (e.n_rw != 0) check("wb_mem_to_reg", wb_sel, e.wb_sel);
    if (!is_fault) begin
      check("retire_illegal", illegal, 0);
      check("retire_timeout_err", timeout_err, 0);
    end
  endtask

  initial begin
    clear_acc();
    in_fault = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clear_acc();
        in_fault = 0;
      end else if (state == 3'd0) begin
        check("idle_outputs_zero", int'({strobes, illegal, timeout_err}), 0);
        clear_acc();
      end else if (state == 3'd6) begin
        if (!in_fault) begin
          in_fault = 1;
          compare_txn(1'b1);
        end
        check("fault_strobes_zero", int'(strobes), 0);
        check("fault_illegal_held", illegal, int'(cur_fault.ill));
        check("fault_timeout_held", timeout_err, int'(cur_fault.tmo));
      end else begin
        cyc++;
        n_rd  += int'(mem_read);
        n_wr  += int'(mem_write);
        n_rw  += int'(reg_write);
        n_br  += int'(branch);
        n_pcw += int'(pc_write);
        n_pcs += int'(pc_src);
        n_irw += int'(ir_write);
        if (state == 3'd3) begin
          ex_op = int'(alu_op); ex_a = int'(alu_src_a); ex_b = int'(alu_src_b);
        end
        if (reg_write) wb_sel = int'(mem_to_reg);
        if (retire) begin
          compare_txn(1'b0);
          clear_acc();
        end else if (cyc > 100) begin
          check("instr_runaway_cycles", cyc, 0);
          clear_acc();
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  bit [6:0] legal_ops [7];

  initial begin
    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};
    #1;
    do_reset();

    // Directed: each class, the boundary waits, illegal opcode.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LD, 0, 3);
    run_instr(OP_ST, 0, 0);
    run_instr(OP_BR, 0, 0);
    run_instr(OP_JAL, 1, 0);
    run_instr(OP_LUI, 0, 0);
    run_instr(OP_I, 2, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(OP_R, 15, 0);
    run_instr(OP_R, 14, 0);
    run_instr(OP_LD, 0, 14);
    run_instr(OP_ST, 0, 15);

    // Random stream.
    for (int n = 0; n < 150; n++) begin
      bit [6:0] op;
      if ($urandom_range(0, 4) == 0) op = rand7();
      else op = legal_ops[$urandom_range(0, 6)];
      run_instr(op, pick_wait(), pick_wait());
    end

    // Asynchronous reset in the middle of a stalled store.
    drive(1'b1, rand7());
    drive(rand1(), OP_ST);
    drive(rand1(), OP_ST);
    drive(1'b0, OP_ST);
    drive(1'b0, OP_ST);
    #2;
    check("store_wait_mem_write", mem_write, 1);
    check("store_wait_state", state, 4);
    rst_n = 1'b0;
    #1;
    check("async_reset_mem_write", mem_write, 0);
    check("async_reset_state", state, 0);
    check("async_reset_retire", retire, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(rand1(), rand7());
    run_instr(OP_R, 0, 0);

    repeat (2) drive(1'b0, rand7());
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
